// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - byte-to-serial framer (start, 8 data MSB-first, optional even parity, stop); option macro SEQ_FRAME_TX_PARITY_EN
module seq_frame_tx #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       IN_VALID,
   input  logic [7:0] IN,
   output logic       IN_READY,
   output logic       TX,
   output logic       BUSY
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd4
   } state_t;
`endif

   state_t          state_q, state_d;
   logic [7:0]      data_q, data_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            tx_q, tx_d;
   logic            bit_done;
   logic            in_ready;
`ifdef SEQ_FRAME_TX_PARITY_EN
   logic            par_q, par_d;
`endif

   assign bit_done = (cnt_q == CNT_LAST);
   assign in_ready = (state_q == IDLE);
   assign IN_READY = in_ready;
   assign BUSY     = ~in_ready;
   assign TX       = tx_q;

   // State register; reset aborts any frame at once and parks the line high
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
`ifdef SEQ_FRAME_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   // Next state; tx_d is the level for the coming cycle, so TX changes only on bit boundaries
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      tx_d    = tx_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_d   = par_q;
`endif

      if (state_q != IDLE) begin
         cnt_d = bit_done ? '0 : cnt_q + CW'(1);
      end

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (IN_VALID && in_ready) begin
               data_d  = IN;
               cnt_d   = '0;
               idx_d   = '0;
               tx_d    = 1'b0;
`ifdef SEQ_FRAME_TX_PARITY_EN
               par_d   = 1'b0;
`endif
               state_d = START;
            end
         end
         START: begin
            if (bit_done) begin
               tx_d    = data_q[7];
               state_d = DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               data_d = {data_q[6:0], 1'b0};
               idx_d  = idx_q + 3'd1;
`ifdef SEQ_FRAME_TX_PARITY_EN
               par_d  = par_q ^ data_q[7];
`endif
               if (idx_q == 3'd7) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
                  tx_d    = par_q ^ data_q[7];
                  state_d = PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = STOP;
`endif
               end else begin
                  tx_d = data_q[6];
               end
            end
         end
`ifdef SEQ_FRAME_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               tx_d    = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               tx_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial framer that takes one byte per valid/ready handshake and drives it onto a single-wire line as a start bit, eight data bits MSB-first, an optional parity bit and a stop bit. Each bit is held for a programmable number of clock cycles. The block sits directly downstream of the byte-wide shift stage. Its internal left-shifting data register produces data bits in the same MSB-first order the shift stage uses, so the two stages agree on bit order without reordering.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `CLK  input  1`: clock; all state updates on posedge.
- `RST  input  1`: asynchronous, active-high reset.
- `IN_VALID  input  1`: the upstream byte on `IN` is valid.
- `IN  input  8`: byte to transmit; sampled only on handshake.
- `IN_READY  output  1`: the block accepts a byte this cycle.
- `TX  output  1`: serial line, idle high.
- `BUSY  output  1`: a frame is in progress; always equal to `~IN_READY`.

## Operation
- States: `IDLE`, `START`, `DATA`, `PARITY` (only if configured), `STOP`.
- **IDLE**
  - `IN_READY=1`, `TX=1`.
  - A handshake is `IN_VALID & IN_READY` at a posedge.
  - On handshake: load `IN` into the 8-bit data register, clear the bit-cycle counter and bit index, and go to `START`.
- **START**
  - `TX=0` for `CLKS_PER_BIT` cycles, then go to `DATA`.
- **DATA**
  - `TX` = data register bit 7.
  - Every `CLKS_PER_BIT` cycles: shift the data register left by 1 and increment the bit index.
  - After 8 bits, go to `PARITY` or `STOP`.
- **PARITY**
  - `TX` = XOR of the 8 captured bits (even parity) for `CLKS_PER_BIT` cycles, then go to `STOP`.
  - The parity value is accumulated while the bits shift out, not recomputed from `IN`.
- **STOP**
  - `TX=1` for `CLKS_PER_BIT` cycles, then go to `IDLE`.
- `IN` and `IN_VALID` are ignored outside `IDLE`. A held `IN_VALID` is accepted on the first cycle back in `IDLE`.
- Bit-cycle counter:
  - Width `$clog2(CLKS_PER_BIT)`.
  - Counts 0..`CLKS_PER_BIT-1`, then wraps to 0 on the bit boundary.
- `TX` is a registered output; it never glitches between bits.

## Timing
- Reset values: `TX=1`, `IN_READY=1`, `BUSY=0`, state `IDLE`, data register 0, counters 0.
- Reset mid-frame: the frame is aborted immediately (asynchronously) and `TX` returns high. No partial frame resumes after reset release.
- Handshake at posedge *n*: `TX` falls and `IN_READY` falls at posedge *n* (registered, visible in cycle *n+1*).
- Frame length is `F·CLKS_PER_BIT` cycles, where F=10 (11 with parity), measured from the first `TX=0` cycle to the last stop cycle inclusive.
- `IN_READY` rises on the posedge ending the last stop cycle.
- The earliest next handshake is that same cycle. Minimum spacing between frame starts is therefore `F·CLKS_PER_BIT+1` cycles, and there is exactly one idle-high cycle between back-to-back frames.
- Simultaneous `RST` and handshake: reset wins and the byte is dropped.

## Configuration
- Macro: `SEQ_FRAME_TX_PARITY_EN`.
- Defined:
  - The `PARITY` state and parity accumulator are compiled in.
  - Frame is 11 bits: start, 8 data, even parity, stop.
- Undefined:
  - No parity logic exists.
  - Frame is 10 bits: start, 8 data, stop.
  - `DATA` transitions directly to `STOP`.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
- Reset release, `IN_VALID=0` for 20 cycles -> `TX=1`, `IN_READY=1`, `BUSY=0` throughout.
- Send 0xA5, no parity -> `TX` holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles; `IN_READY` low for exactly 40 cycles.
- With `SEQ_FRAME_TX_PARITY_EN`:
  - Send 0xA5 -> parity bit 0 after the data bits, 44-cycle frame.
  - Send 0x01 -> parity bit 1.
- `IN_VALID` held high with 0x3C then 0xC3 presented back-to-back -> two frames separated by exactly one `TX=1` idle cycle; `IN` changes during the first frame do not corrupt it.
- Assert `RST` for 1 cycle at the 3rd data bit of 0xFF -> `TX=1` immediately. After release, `IN_READY=1` and the next byte 0x80 transmits correctly.
- `CLKS_PER_BIT=2` with 0x00 -> start and 8 data bits low for 18 cycles, then stop high for 2 cycles.
